bidir_bus_hub: RTL
==================

Name: bidir_bus_hub

Overview:
Parametrised DSP external-bus front end that replaces the fixed 16-bit bidirectional bus block. It qualifies DSP read and write cycles and captures write address and data after a configurable settle delay. Each write produces exactly one strobe to the sub-modules. It muxes NSLV sub-module read ports onto the tri-stated data bus by priority and flags protocol errors (timeout, read/write conflict) in sticky status bits. It sits directly under the FPGA top level, between the DSP pins and the application sub-modules.

Parameters:
DW, 16, data bus width
AW, 8, address bus width
NSLV, 4, number of read-capable sub-modules (1..8)
WE_DELAY, 2, xclk cycles we must stay qualified before capture (1..7)
AB_OFFSET, 0, subtracted from ab before presentation to sub-modules (modulo 2^AW)
TIMEOUT, 255, max cycles a qualified access may last before error (8-bit, >=4)
IDLE_PATTERN, 16'h3333, driven on read when no sub-module claims (truncated/zero-extended to DW)

Ports:
xclk  in  1  master clock, DSP external bus clock
reset  in  1  asynchronous, active-high reset
db  inout  DW  DSP bidirectional data bus
re  in  1  read enable, active low
we  in  1  write enable, active low
cs  in  1  chip select, active low
ab  in  AW  DSP address bus
wr_strobe  out  1  one-cycle write pulse to sub-modules
wr_addr  out  AW  captured address minus AB_OFFSET, valid with wr_strobe
wr_data  out  DW  captured data, valid with wr_strobe
rd_qual  out  1  combinational (!re & !cs & we), read request to sub-modules
rd_addr  out  AW  combinational ab minus AB_OFFSET
slv_rd_data  in  NSLV*DW  sub-module read data, slot i at [i*DW +: DW]
slv_rd_avail  in  NSLV  sub-module i claims current read
err_clear  in  1  synchronous pulse, clears sticky errors
err_timeout  out  1  sticky, access exceeded TIMEOUT
err_conflict  out  1  sticky, re and we both low with cs low
rd_miss  out  1  sticky, read completed with no slv_rd_avail
wr_count  out  16  completed write strobes, wraps at 16'hFFFF -> 0

Behaviour:
- Reset: db tri-stated; wr_strobe=0; wr_addr=0; wr_data=0; all error flags=0; wr_count=0; write FSM in W_IDLE; read output enable=0. Reset takes effect mid-access immediately: no strobe issued, bus released within the same cycle.
- Write qualified = !we & !cs & re.
- Write FSM:
  - W_IDLE: go to W_SETTLE when write qualified; load settle count = 1.
  - W_SETTLE: while qualified, increment the count. When the count reaches WE_DELAY, go to W_CAPTURE. If qualification drops, return to W_IDLE with no strobe.
  - W_CAPTURE, one cycle: register ab-AB_OFFSET into wr_addr and db into wr_data, pulse wr_strobe=1, increment wr_count, go to W_HOLD.
  - W_HOLD: wait until we=1 or cs=1, then go to W_IDLE. A held-low we yields exactly one strobe.
  - Latency: wr_strobe asserts WE_DELAY+1 cycles after the first xclk edge that samples write qualified.
- Read path:
  - Output enable and output data register are updated every xclk edge.
  - While rd_qual=1 and no timeout lockout: oe<=1; data<=slv_rd_data of the lowest index i with slv_rd_avail[i]=1, else IDLE_PATTERN.
  - rd_qual=0: oe<=0.
  - One-cycle latency from rd_qual to db driven; db is released one cycle after re or cs rises.
- rd_miss: set on the last cycle of a read (rd_qual falling) if no avail bit was seen during that read.
- Access timer:
  - 8-bit counter, cleared whenever cs=1 or (re=1 & we=1); otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: set err_timeout, force oe=0, and lock out reads until the access ends. The write FSM returns to W_IDLE with no strobe if still in W_SETTLE.
- Conflict: re=0 & we=0 & cs=0 sets err_conflict, forces oe=0, and suppresses any capture. The write FSM goes to W_HOLD.
- err_clear clears all sticky flags. If a set condition coincides with err_clear in the same cycle, the set wins.
- Address subtraction wraps modulo 2^AW.

Test Plan:
- Write, WE_DELAY=2, AB_OFFSET=8'h10: cs=0, we=0 for 6 cycles, ab=8'h25, db=16'hA5C3 -> single wr_strobe 3 cycles after first qualified edge, wr_addr=8'h15, wr_data=16'hA5C3, wr_count=1.
- Aborted write: we low 1 cycle with WE_DELAY=2 -> no wr_strobe, wr_count unchanged, no error.
- Priority read: slv_rd_avail=4'b0110, slot1=16'h1111, slot2=16'h2222, re=0 for 4 cycles -> db=16'h1111 from cycle 2, tri-state one cycle after re rises; with avail=0 -> db=16'h3333 and rd_miss=1.
- Timeout, TIMEOUT=8: re=0, cs=0 held for 20 cycles -> err_timeout=1 at cycle 8, db tri-stated from cycle 9 until re rises; err_clear -> err_timeout=0.
- Conflict: re=0, we=0, cs=0 for 5 cycles -> err_conflict=1, db never driven, no wr_strobe.
- Reset mid-read at cycle 2 -> db high-Z the same cycle, all outputs at reset values; wr_count wraps 16'hFFFF->0 after the next write.

Source files
------------

// File: rtl/bidir_bus_hub.sv
// DSP external-bus front end: qualifies read/write cycles, issues one write strobe
// per DSP write, muxes sub-module read data onto the tri-stated bus, flags protocol errors.
module bidir_bus_hub #(
  parameter int              DW           = 16,
  parameter int              AW           = 8,
  parameter int              NSLV         = 4,
  parameter int              WE_DELAY     = 2,
  parameter logic [AW-1:0]   AB_OFFSET    = '0,
  parameter int              TIMEOUT      = 255,
  parameter logic [15:0]     IDLE_PATTERN = 16'h3333
) (
  input  logic               xclk,
  input  logic               reset,
  inout  wire  [DW-1:0]      db,
  input  logic               re,
  input  logic               we,
  input  logic               cs,
  input  logic [AW-1:0]      ab,
  output logic               wr_strobe,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               rd_qual,
  output logic [AW-1:0]      rd_addr,
  input  logic [NSLV*DW-1:0] slv_rd_data,
  input  logic [NSLV-1:0]    slv_rd_avail,
  input  logic               err_clear,
  output logic               err_timeout,
  output logic               err_conflict,
  output logic               rd_miss,
  output logic [15:0]        wr_count
);

  localparam logic [2:0]    WE_DELAY_C = 3'(WE_DELAY);
  localparam logic [7:0]    TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [DW-1:0] IDLE_DW    = DW'(IDLE_PATTERN);

  typedef enum logic [1:0] {W_IDLE, W_SETTLE, W_CAPTURE, W_HOLD} wstate_e;

  wstate_e       state_q, state_d;
  logic [2:0]    settle_q, settle_d;
  logic [7:0]    tmr_q, tmr_d;
  logic          wr_strobe_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [15:0]   wr_count_q;
  logic          oe_q, oe_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          seen_q, seen_d;
  logic          rd_prev_q;
  logic          err_timeout_q, err_timeout_d;
  logic          err_conflict_q, err_conflict_d;
  logic          rd_miss_q, rd_miss_d;

  logic wr_qual, conflict, acc_idle, lockout, timeout_set;

  assign wr_qual  = !we && !cs && re;
  assign conflict = !re && !we && !cs;
  assign acc_idle = cs || (re && we);
  assign rd_qual  = !re && !cs && we;
  assign rd_addr  = ab - AB_OFFSET;
  assign lockout  = (tmr_q == TIMEOUT_C);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    tmr_d = tmr_q;
    if (acc_idle)                tmr_d = '0;
    else if (tmr_q != TIMEOUT_C) tmr_d = tmr_q + 8'd1;
  end

  // Flag on the edge the timer arrives at TIMEOUT; bus lockout follows one cycle later.
  assign timeout_set = !acc_idle && (tmr_d == TIMEOUT_C);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      W_IDLE: begin
        if (wr_qual && !lockout) begin
          state_d  = W_SETTLE;
          settle_d = 3'd1;
        end
      end
      W_SETTLE: begin
        if (!wr_qual || lockout)         state_d  = W_IDLE;
        else if (settle_q == WE_DELAY_C) state_d  = W_CAPTURE;
        else                             settle_d = settle_q + 3'd1;
      end
      W_CAPTURE: state_d = W_HOLD;
      W_HOLD:    if (we || cs) state_d = W_IDLE;
      default:   state_d = W_IDLE;
    endcase
    if (conflict) state_d = W_HOLD;
  end

  always_comb begin
    rdata_d = IDLE_DW;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (slv_rd_avail[i]) rdata_d = slv_rd_data[i*DW +: DW];
    end
    oe_d = rd_qual && !lockout && !conflict;
  end

  // Set beats a coincident clear on every sticky flag.
  always_comb begin
    seen_d         = rd_qual && (seen_q || (|slv_rd_avail));
    err_timeout_d  = (err_timeout_q  && !err_clear) || timeout_set;
    err_conflict_d = (err_conflict_q && !err_clear) || conflict;
    rd_miss_d      = (rd_miss_q      && !err_clear) || (rd_prev_q && !rd_qual && !seen_q);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so the bus drops immediately.
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      state_q        <= W_IDLE;
      settle_q       <= '0;
      tmr_q          <= '0;
      wr_strobe_q    <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_count_q     <= '0;
      oe_q           <= 1'b0;
      rdata_q        <= '0;
      seen_q         <= 1'b0;
      rd_prev_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_conflict_q <= 1'b0;
      rd_miss_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      tmr_q          <= tmr_d;
      wr_strobe_q    <= (state_d == W_CAPTURE);
      if (state_d == W_CAPTURE) begin
        wr_addr_q  <= rd_addr;
        wr_data_q  <= db;
        wr_count_q <= wr_count_q + 16'd1;
      end
      oe_q           <= oe_d;
      rdata_q        <= rdata_d;
      seen_q         <= seen_d;
      rd_prev_q      <= rd_qual;
      err_timeout_q  <= err_timeout_d;
      err_conflict_q <= err_conflict_d;
      rd_miss_q      <= rd_miss_d;
    end
  end

  assign db           = oe_q ? rdata_q : {DW{1'bz}};
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_count     = wr_count_q;
  assign err_timeout  = err_timeout_q;
  assign err_conflict = err_conflict_q;
  assign rd_miss      = rd_miss_q;

endmodule
